// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB with one shared
// memory and one ALU, counts retired instructions and traps on illegal
// opcodes or memory timeouts.
//
// Memory handshake: the FSM holds its access strobe (MRead or MWrite) and
// address select steady in FETCH/MEM_READ/MEM_WRITE until the cycle in which
// mem_ready=1; that cycle completes the access and the FSM advances on the
// following edge. There is no back-pressure from the FSM to memory.
module mc_ctrl_fsm #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Op,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MRead,
    output logic             MWrite,
    output logic             IRWrite,
    output logic             MtoR,
    output logic             RegDs,
    output logic             Urw,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       AOp,
    output logic             PCSrc,
    output logic [3:0]       state,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_TRAP      = 4'd15
    } state_t;

    // Registered Moore control word (PCWrite/IRWrite are handled separately).
    typedef struct packed {
        logic       pcwrite_cond;
        logic       iord;
        logic       mread;
        logic       mwrite;
        logic       mtor;
        logic       regds;
        logic       urw;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aop;
        logic       pcsrc;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

    state_t            state_q, state_n;
    logic [5:0]        op_q, op_n;
    logic [1:0]        err_q, err_n;
    logic [TO_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]  cnt_q;
    ctrl_t             ctrl_q;
    logic              waiting;
    logic              retire;

    // Control word for a given state; op selects the ALU op where it matters.
    function automatic ctrl_t decode_ctrl(input state_t st, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH:     begin c.mread = 1'b1; c.alusrcb = 2'b01; end
            S_DECODE:    c.alusrcb = 2'b11;
            S_MEM_ADDR:  begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aop     = (op == OP_SW) ? 3'b111 : 3'b000;
            end
            S_MEM_READ:  begin c.mread = 1'b1; c.iord = 1'b1; end
            S_MEM_WB:    begin c.urw = 1'b1; c.mtor = 1'b1; end
            S_MEM_WRITE: begin c.mwrite = 1'b1; c.iord = 1'b1; end
            S_R_EXEC:    begin c.alusrca = 1'b1; c.aop = 3'b010; end
            S_R_WB:      begin c.urw = 1'b1; c.regds = 1'b1; end
            S_BRANCH:    begin
                c.alusrca      = 1'b1;
                c.aop          = 3'b001;
                c.pcwrite_cond = 1'b1;
                c.pcsrc        = 1'b1;
            end
            S_I_EXEC:    begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                case (op)
                    OP_ADDI: c.aop = 3'b011;
                    OP_SLTI: c.aop = 3'b100;
                    OP_ANDI: c.aop = 3'b101;
                    OP_ORI:  c.aop = 3'b110;
                    default: c.aop = 3'b000;
                endcase
            end
            S_I_WB:      c.urw = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                     (state_q == S_MEM_WRITE);
    assign retire  = (state_n == S_FETCH) &&
                     ((state_q == S_MEM_WB) || (state_q == S_MEM_WRITE) ||
                      (state_q == S_R_WB)   || (state_q == S_BRANCH)    ||
                      (state_q == S_I_WB));

    // Next-state, opcode latch and first-error capture.
    always_comb begin
        state_n = state_q;
        op_n    = op_q;
        err_n   = err_q;
        case (state_q)
            S_IDLE:      state_n = S_FETCH;
            S_FETCH: begin
                if (mem_ready) state_n = S_DECODE;
                else if (wait_cnt == TIMEOUT_C) begin
                    state_n = S_TRAP;
                    err_n   = 2'b10;
                end
            end
            S_DECODE: begin
                op_n = Op;
                case (Op)
                    OP_RTYPE:                          state_n = S_R_EXEC;
                    OP_LW, OP_SW:                      state_n = S_MEM_ADDR;
                    OP_BEQ:                            state_n = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_n = S_I_EXEC;
                    default: begin
                        state_n = S_TRAP;
                        err_n   = 2'b01;
                    end
                endcase
            end
            S_MEM_ADDR:  state_n = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (mem_ready) state_n = S_MEM_WB;
                else if (wait_cnt == TIMEOUT_C) begin
                    state_n = S_TRAP;
                    err_n   = 2'b10;
                end
            end
            S_MEM_WRITE: begin
                if (mem_ready) state_n = S_FETCH;
                else if (wait_cnt == TIMEOUT_C) begin
                    state_n = S_TRAP;
                    err_n   = 2'b10;
                end
            end
            S_MEM_WB, S_R_WB, S_BRANCH, S_I_WB: state_n = S_FETCH;
            S_R_EXEC:    state_n = S_R_WB;
            S_I_EXEC:    state_n = S_I_WB;
            S_TRAP:      state_n = S_TRAP;
            default:     state_n = S_IDLE;
        endcase
    end

    // State, registered controls, wait counter and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            err_q    <= 2'b00;
            wait_cnt <= '0;
            cnt_q    <= '0;
            ctrl_q   <= '0;
        end else begin
            state_q <= state_n;
            op_q    <= op_n;
            err_q   <= err_n;
            ctrl_q  <= decode_ctrl(state_n, op_n);
            if (state_n != state_q)
                wait_cnt <= '0;
            else if (waiting && !mem_ready)
                wait_cnt <= wait_cnt + TO_W'(1);
            if (retire)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // FETCH loads IR and PC in the same cycle memory returns the instruction.
    assign PCWrite     = (state_q == S_FETCH) && mem_ready;
    assign IRWrite     = (state_q == S_FETCH) && mem_ready;
    assign PCWriteCond = ctrl_q.pcwrite_cond;
    assign IorD        = ctrl_q.iord;
    assign MRead       = ctrl_q.mread;
    assign MWrite      = ctrl_q.mwrite;
    assign MtoR        = ctrl_q.mtor;
    assign RegDs       = ctrl_q.regds;
    assign Urw         = ctrl_q.urw;
    assign ALUSrcA     = ctrl_q.alusrca;
    assign ALUSrcB     = ctrl_q.alusrcb;
    assign AOp         = ctrl_q.aop;
    assign PCSrc       = ctrl_q.pcsrc;
    assign state       = state_q;
    assign err_code    = err_q;
    assign instr_cnt   = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: instruction-level reference model that
// expands each opcode plus its memory wait counts into the expected per-cycle
// state/control trace, with randomized opcodes, waits and don't-care inputs.
module tb_mc_ctrl_fsm;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       op = 6'd0;
    logic             mem_ready = 1'b0;
    logic             PCWrite, PCWriteCond, IorD, MRead, MWrite, IRWrite;
    logic             MtoR, RegDs, Urw, ALUSrcA, PCSrc;
    logic [1:0]       ALUSrcB;
    logic [2:0]       AOp;
    logic [3:0]       state;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] instr_cnt;

    int         checks = 0;
    int         errors = 0;
    int         exp_cnt = 0;
    logic [1:0] exp_err = 2'b00;

    localparam logic [5:0] R_OP = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                           BEQ = 6'b000100, ADDI = 6'b001000, SLTI = 6'b001010,
                           ANDI = 6'b001100, ORI = 6'b001101;
    logic [5:0] legal_ops [8] = '{R_OP, LW, SW, BEQ, ADDI, SLTI, ANDI, ORI};

    mc_ctrl_fsm #(.CNT_W(CNT_W), .TIMEOUT(15), .TO_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .Op(op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MRead(MRead), .MWrite(MWrite), .IRWrite(IRWrite), .MtoR(MtoR),
        .RegDs(RegDs), .Urw(Urw), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .AOp(AOp), .PCSrc(PCSrc), .state(state), .err_code(err_code),
        .instr_cnt(instr_cnt)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] obs_ctrl;
    assign obs_ctrl = {PCWrite, PCWriteCond, IorD, MRead, MWrite, IRWrite, MtoR,
                       RegDs, Urw, ALUSrcA, ALUSrcB, AOp, PCSrc};

    // Pack a control word in the same order as obs_ctrl.
    function automatic logic [15:0] mk(input logic pcw, input logic pcc,
            input logic iord, input logic mrd, input logic mwr, input logic irw,
            input logic mtor, input logic regds, input logic urw,
            input logic srca, input logic [1:0] srcb, input logic [2:0] aop,
            input logic pcsrc);
        return {pcw, pcc, iord, mrd, mwr, irw, mtor, regds, urw, srca, srcb, aop, pcsrc};
    endfunction

    function automatic logic [2:0] i_aop(input logic [5:0] o);
        case (o)
            ADDI:    return 3'b011;
            SLTI:    return 3'b100;
            ANDI:    return 3'b101;
            ORI:     return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(0, 63));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, check outputs, advance to next negedge.
    task automatic step(input logic mr, input logic [5:0] o, input logic [3:0] st,
                        input logic [15:0] ctrl);
        mem_ready = mr;
        op = o;
        #1;
        chk($sformatf("state(exp %0d)", st), 32'(state), 32'(st));
        chk($sformatf("ctrl(st %0d)", st), 32'(obs_ctrl), 32'(ctrl));
        chk("instr_cnt", 32'(instr_cnt), 32'(exp_cnt & 16'hFFFF));
        chk("err_code", 32'(err_code), 32'(exp_err));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        op = 6'd0;
        exp_cnt = 0;
        exp_err = 2'b00;
        @(negedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ctrl", 32'(obs_ctrl), 32'd0);
        chk("rst_cnt", 32'(instr_cnt), 32'd0);
        chk("rst_err", 32'(err_code), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(rbit(), rnd_op(), 4'd0, 16'd0);
    endtask

    // A memory-wait phase: waits cycles of mem_ready=0, more than 15 traps.
    task automatic run_wait(input logic [3:0] st, input logic [15:0] ctrl_wait,
                            input logic [15:0] ctrl_done, input int waits,
                            output bit trapped);
        for (int i = 0; i < waits && i < 16; i++) step(1'b0, rnd_op(), st, ctrl_wait);
        if (waits > 15) begin
            exp_err = 2'b10;
            trapped = 1'b1;
        end else begin
            step(1'b1, rnd_op(), st, ctrl_done);
            trapped = 1'b0;
        end
    endtask

    // Expected trace for one instruction from FETCH until the next FETCH.
    task automatic run_instr(input logic [5:0] o, input int fw, input int mw);
        bit t;
        run_wait(4'd1, mk(0,0,0,1,0,0,0,0,0,0,2'b01,3'b000,0),
                 mk(1,0,0,1,0,1,0,0,0,0,2'b01,3'b000,0), fw, t);
        if (t) return;
        step(rbit(), o, 4'd2, mk(0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,0));
        case (o)
            R_OP: begin
                step(rbit(), rnd_op(), 4'd7, mk(0,0,0,0,0,0,0,0,0,1,2'b00,3'b010,0));
                step(rbit(), rnd_op(), 4'd8, mk(0,0,0,0,0,0,0,1,1,0,2'b00,3'b000,0));
                exp_cnt++;
            end
            LW: begin
                step(rbit(), rnd_op(), 4'd3, mk(0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,0));
                run_wait(4'd4, mk(0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,0),
                         mk(0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,0), mw, t);
                if (t) return;
                step(rbit(), rnd_op(), 4'd5, mk(0,0,0,0,0,0,1,0,1,0,2'b00,3'b000,0));
                exp_cnt++;
            end
            SW: begin
                step(rbit(), rnd_op(), 4'd3, mk(0,0,0,0,0,0,0,0,0,1,2'b10,3'b111,0));
                run_wait(4'd6, mk(0,0,1,0,1,0,0,0,0,0,2'b00,3'b000,0),
                         mk(0,0,1,0,1,0,0,0,0,0,2'b00,3'b000,0), mw, t);
                if (t) return;
                exp_cnt++;
            end
            BEQ: begin
                step(rbit(), rnd_op(), 4'd9, mk(0,1,0,0,0,0,0,0,0,1,2'b00,3'b001,1));
                exp_cnt++;
            end
            ADDI, SLTI, ANDI, ORI: begin
                step(rbit(), rnd_op(), 4'd10, mk(0,0,0,0,0,0,0,0,0,1,2'b10,i_aop(o),0));
                step(rbit(), rnd_op(), 4'd11, mk(0,0,0,0,0,0,0,0,1,0,2'b00,3'b000,0));
                exp_cnt++;
            end
            default: exp_err = 2'b01;
        endcase
    endtask

    task automatic trap_steps(input int n);
        for (int i = 0; i < n; i++) step(rbit(), rnd_op(), 4'd15, 16'd0);
    endtask

    // Directed and random stimulus sequence
    initial begin
        bit t;
        int fw, mw;
        do_reset();
        run_instr(R_OP, 0, 0);
        run_instr(LW, 0, 3);
        run_instr(SW, 0, 0);
        run_instr(BEQ, 0, 0);
        run_instr(ADDI, 1, 0);
        run_instr(SLTI, 1, 0);
        run_instr(ANDI, 1, 0);
        run_instr(ORI, 1, 0);
        run_instr(R_OP, 15, 0);
        run_instr(LW, 0, 15);
        run_instr(SW, 2, 15);
        for (int i = 0; i < 40; i++) begin
            fw = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
            mw = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
            run_instr(legal_ops[$urandom_range(0, 7)], fw, mw);
        end
        run_instr(6'b111111, 0, 0);
        trap_steps(20);

        do_reset();
        run_instr(BEQ, 0, 0);
        run_wait(4'd1, mk(0,0,0,1,0,0,0,0,0,0,2'b01,3'b000,0),
                 mk(1,0,0,1,0,1,0,0,0,0,2'b01,3'b000,0), 16, t);
        trap_steps(10);

        do_reset();
        run_instr(LW, 0, 16);
        trap_steps(5);

        do_reset();
        run_instr(SW, 0, 16);
        trap_steps(5);

        // Asynchronous reset in the middle of a memory write.
        do_reset();
        run_instr(R_OP, 0, 0);
        step(1'b1, rnd_op(), 4'd1, mk(1,0,0,1,0,1,0,0,0,0,2'b01,3'b000,0));
        step(rbit(), SW, 4'd2, mk(0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,0));
        step(rbit(), rnd_op(), 4'd3, mk(0,0,0,0,0,0,0,0,0,1,2'b10,3'b111,0));
        mem_ready = 1'b0;
        #1;
        chk("mw_state", 32'(state), 32'd6);
        chk("mw_strobe", 32'(MWrite), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_mwrite", 32'(MWrite), 32'd0);
        chk("async_ctrl", 32'(obs_ctrl), 32'd0);
        chk("async_state", 32'(state), 32'd0);
        chk("async_cnt", 32'(instr_cnt), 32'd0);
        exp_cnt = 0;
        exp_err = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        step(rbit(), rnd_op(), 4'd0, 16'd0);
        run_instr(ORI, 0, 0);
        step(1'b1, rnd_op(), 4'd1, mk(1,0,0,1,0,1,0,0,0,0,2'b01,3'b000,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the MIPS-subset datapath.
- Replaces the single-cycle opcode decoder with a Moore FSM that steps one instruction through FETCH/DECODE/EXEC/MEM/WB using one shared memory and one ALU.
- Handshakes with memory through mem_ready and counts retired instructions.
- Traps on illegal opcodes and on memory timeouts.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- TIMEOUT, 15, max cycles waiting for mem_ready before trap (1..2^TO_W-1)
- TO_W, 4, width of wait counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- Op  in  6  opcode field from instruction register (valid from DECODE onward)
- mem_ready  in  1  memory completes current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero (ANDed in datapath)
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- MRead  out  1  memory read strobe
- MWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MtoR  out  1  1 = write-back from MDR, 0 = from ALUOut
- RegDs  out  1  1 = rd destination, 0 = rt
- Urw  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- AOp  out  3  ALU-control op, existing encoding: 000 add, 001 sub, 010 funct, 011 addi, 100 slti, 101 andi, 110 ori, 111 sw-add
- PCSrc  out  1  0 = ALU result, 1 = ALUOut
- state  out  4  current state code (debug)
- err_code  out  2  00 none, 01 illegal opcode, 10 memory timeout
- instr_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, op_q=0, wait_cnt=0, instr_cnt=0, err_code=00.
  - All strobes 0, all selects 0.
- State codes: IDLE0, FETCH1, DECODE2, MEM_ADDR3, MEM_READ4, MEM_WB5, MEM_WRITE6, R_EXEC7, R_WB8, BRANCH9, I_EXEC10, I_WB11, TRAP15.
- Outputs are Moore decodes of state (unlisted outputs are 0). Exception: in FETCH, IRWrite and PCWrite = mem_ready.
- IDLE: all 0 -> FETCH.
- FETCH: MRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, AOp=000, PCSrc=0.
  - Stay while mem_ready=0; on mem_ready=1 -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, AOp=000 (branch target precompute). Latch op_q=Op.
  - Next state by Op: 000000 -> R_EXEC; 100011/101011 -> MEM_ADDR; 000100 -> BRANCH; 001000/001010/001100/001101 -> I_EXEC.
  - Any other Op -> TRAP with err_code=01.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, AOp=000 for LW, 111 for SW -> MEM_READ (LW) or MEM_WRITE (SW), per op_q.
- MEM_READ: MRead=1, IorD=1; on mem_ready -> MEM_WB.
- MEM_WB: Urw=1, MtoR=1, RegDs=0 -> FETCH.
- MEM_WRITE: MWrite=1, IorD=1; on mem_ready -> FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, AOp=010 -> R_WB.
- R_WB: Urw=1, MtoR=0, RegDs=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, AOp=001, PCWriteCond=1, PCSrc=1 -> FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, AOp = 011 addi / 100 slti / 101 andi / 110 ori (from op_q) -> I_WB.
- I_WB: Urw=1, MtoR=0, RegDs=0 -> FETCH.
- Wait counter:
  - Counts cycles spent in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - Cleared on any state change.
  - When wait_cnt==TIMEOUT and mem_ready=0 -> TRAP, err_code=10.
  - mem_ready=1 in that same cycle wins: normal advance, no trap.
- instr_cnt:
  - +1 on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH or I_WB.
  - Wraps modulo 2^CNT_W.
  - Not incremented for IDLE->FETCH.
- TRAP: all strobes 0; sticky until rst_n; err_code holds. First error wins.
- Strobe exclusivity: MRead/MWrite never high together; Urw never high with MWrite.
- Reset mid-operation: outputs drop to 0 asynchronously (no strobe glitch past rst_n fall); restart from IDLE.

Test Plan:
- Release reset, mem_ready=1, Op=000000 -> state 0,1,2,7,8,1. Urw=1 and RegDs=1 only in R_WB. instr_cnt=1 on re-entering FETCH.
- LW (100011), mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles with MRead=1, IorD=1, then MEM_WB with Urw=1, MtoR=1. Total 8 cycles FETCH to FETCH.
- SW (101011) then BEQ (000100) -> MEM_ADDR AOp=111, MWrite=1 one cycle; BRANCH AOp=001, PCWriteCond=1, PCSrc=1. instr_cnt +2.
- I-type opcodes 001000/001010/001100/001101 -> I_EXEC AOp = 011/100/101/110, ALUSrcB=10, I_WB RegDs=0.
- Op=111111 in DECODE -> state=15, err_code=01, all strobes 0 for 20 cycles despite input activity. Later mem_ready toggles do not change err_code.
- mem_ready stuck 0 in FETCH, TIMEOUT=15 -> TRAP after 16 cycles, err_code=10.
- Separately, mem_ready=1 exactly at wait_cnt=15 -> normal DECODE.
- Assert rst_n low during MEM_WRITE -> MWrite falls immediately; after release, state IDLE, instr_cnt=0.
